// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: ALUControl codes, FSM state type
// and the shift-op classifier. Also imported by the ALU decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter used when ALU_BARREL_SHIFT_EN is undefined.
// result presents the next shifted value; done flags that the coming shift is the last.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [3:0]             op,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   done
);

    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = {SHAMT_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0]  work_r;
    logic [SHAMT_WIDTH-1:0] count_r;
    logic                   left_r;
    logic                   arith_r;
    logic                   sign_r;
    logic [DATA_WIDTH-1:0]  shift_next_s;
    logic                   fill_s;

    // One-bit step of the working register; sra refills with the captured sign.
    always_comb begin
        fill_s       = 1'b0;
        shift_next_s = work_r;
        if (left_r) begin
            shift_next_s = {work_r[DATA_WIDTH-2:0], 1'b0};
        end else begin
            fill_s       = arith_r ? sign_r : 1'b0;
            shift_next_s = {fill_s, work_r[DATA_WIDTH-1:1]};
        end
    end

    // Working register and remaining-count bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r  <= {DATA_WIDTH{1'b0}};
            count_r <= CNT_ZERO;
            left_r  <= 1'b0;
            arith_r <= 1'b0;
            sign_r  <= 1'b0;
        end else if (load) begin
            work_r  <= data;
            count_r <= shamt;
            left_r  <= (op == ALU_SLL);
            arith_r <= (op == ALU_SRA);
            sign_r  <= data[DATA_WIDTH-1];
        end else if (count_r != CNT_ZERO) begin
            work_r  <= shift_next_s;
            count_r <= count_r - CNT_ONE;
        end else begin
            work_r  <= work_r;
            count_r <= count_r;
        end
    end

    assign result = shift_next_s;
    assign done   = (count_r == CNT_ONE);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and registered ALUResult/Zero.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise shifts are serial.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int SHAMT_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    input  logic [DATA_WIDTH-1:0]     SrcA,
    input  logic [DATA_WIDTH-1:0]     SrcB,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     ALUResult,
    output logic                      Zero,
    output logic                      busy
);

    alu_state_t             state_r;
    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  result_r;
    logic                   zero_r;
    logic [DATA_WIDTH-1:0]  comb_result_s;
    logic [SHAMT_WIDTH-1:0] shamt_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   shift_start_s;
    logic                   shift_done_s;
    logic [DATA_WIDTH-1:0]  shift_result_s;

    assign shamt_s    = SrcB[SHAMT_WIDTH-1:0];
    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Single-cycle datapath; in the serial build a shift only lands here with shamt == 0.
    always_comb begin
        comb_result_s = SrcA + SrcB;
        case (ALUControl)
            ALU_ADD:   comb_result_s = SrcA + SrcB;
            ALU_SUB:   comb_result_s = SrcA - SrcB;
            ALU_SLT:   comb_result_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU:  comb_result_s = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            ALU_XOR:   comb_result_s = SrcA ^ SrcB;
            ALU_OR:    comb_result_s = SrcA | SrcB;
            ALU_AND:   comb_result_s = SrcA & SrcB;
            ALU_PASSB: comb_result_s = SrcB;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:   comb_result_s = SrcA << shamt_s;
            ALU_SRL:   comb_result_s = SrcA >> shamt_s;
            ALU_SRA:   comb_result_s = $signed(SrcA) >>> shamt_s;
`else
            ALU_SLL:   comb_result_s = SrcA;
            ALU_SRL:   comb_result_s = SrcA;
            ALU_SRA:   comb_result_s = SrcA;
`endif
            default:   comb_result_s = SrcA + SrcB;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign shift_start_s  = 1'b0;
    assign shift_done_s   = 1'b0;
    assign shift_result_s = {DATA_WIDTH{1'b0}};
    assign busy           = 1'b0;
`else
    logic busy_r;

    assign shift_start_s = accept_s && is_shift(ALUControl) && (shamt_s != {SHAMT_WIDTH{1'b0}});

    alu_serial_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (shift_start_s),
        .op     (ALUControl),
        .data   (SrcA),
        .shamt  (shamt_s),
        .result (shift_result_s),
        .done   (shift_done_s)
    );

    // busy mirrors residency in SHIFT without decoding state combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else if (shift_start_s) begin
            busy_r <= 1'b1;
        end else if ((state_r == SHIFT) && shift_done_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_r;
        end
    end

    assign busy = busy_r;
`endif

    // Control FSM and result registers; ALUResult/Zero change only on a new write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {DATA_WIDTH{1'b0}};
            zero_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s && shift_start_s) begin
                        state_r     <= SHIFT;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= comb_result_s;
                        zero_r      <= (comb_result_s == {DATA_WIDTH{1'b0}});
                    end else if ((state_r == DONE) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                SHIFT: begin
                    if (shift_done_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= shift_result_s;
                        zero_r      <= (shift_result_s == {DATA_WIDTH{1'b0}});
                    end else begin
                        state_r     <= SHIFT;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign ALUResult = result_r;
    assign Zero      = zero_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with a result scoreboard.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    logic [32:0] sb[$];
    int          pop_cyc[$];
    logic [32:0] exp_v;

    alu_exec_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]         sh;
        logic signed [31:0] sa;
        sh = b[4:0];
        sa = a;
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a << sh;
            4'b0011: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'b0100: return (a < b) ? 32'd1 : 32'd0;
            4'b0101: return a ^ b;
            4'b0110: return a >> sh;
            4'b0111: return sa >>> sh;
            4'b1000: return a | b;
            4'b1001: return a & b;
            4'b1011: return b;
            default: return a + b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_v = sb.pop_front();
                chk("sb_result", ALUResult, exp_v[31:0]);
                chk("sb_zero", {31'd0, Zero}, {31'd0, exp_v[32]});
            end
        end
    end

    // Call between a posedge and the following negedge; returns 1 ns after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int n;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        in_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        m = model(op, a, b);
        sb.push_back({(m == 32'd0), m});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        lat  = 1;
        bcnt = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int bz);
        issue(op, a, b);
        wait_out(tag, lat, bz);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        bit barrel;
`ifdef ALU_BARREL_SHIFT_EN
        barrel = 1'b1;
`else
        barrel = 1'b0;
`endif
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        ALUControl = ALU_ADD;
        SrcA       = 32'd1;
        SrcB       = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        run("sub", ALU_SUB, 32'd5, 32'd5, 1, 0);
        chk("sub_zero", {31'd0, Zero}, 32'd1);
        run("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1, 0);
        chk("slt_val", ALUResult, 32'd1);
        run("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 0);
        chk("sltu_val", ALUResult, 32'd0);
        run("passb", ALU_PASSB, 32'hDEAD_BEEF, 32'h1234_5000, 1, 0);
        chk("passb_val", ALUResult, 32'h1234_5000);
        run("add", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 1, 0);
        run("or", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1, 0);
        run("and", ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 0);

        run("sra4", ALU_SRA, 32'h8000_0000, 32'd4, barrel ? 1 : 5, barrel ? 0 : 4);
        chk("sra4_val", ALUResult, 32'hF800_0000);
        run("sll31", ALU_SLL, 32'd1, 32'd31, barrel ? 1 : 32, barrel ? 0 : 31);
        chk("sll31_val", ALUResult, 32'h8000_0000);
        run("srl0", ALU_SRL, 32'h9ABC_DEF0, 32'h0000_0020, 1, 0);
        chk("srl0_val", ALUResult, 32'h9ABC_DEF0);
        run("srl3", ALU_SRL, 32'hF000_0001, 32'd3, barrel ? 1 : 4, barrel ? 0 : 3);
        run("sra1_pos", ALU_SRA, 32'h4000_0002, 32'd1, barrel ? 1 : 2, barrel ? 0 : 1);

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd7, 32'd8);
        wait_out("bp_add", 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", ALUResult, 32'd15);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(ALU_XOR, 32'hA5A5_0000, 32'h0F0F_FFFF);
        wait_out("bp_xor", 1, 0);
        chk("bp_xor_val", ALUResult, 32'hAAAA_FFFF);
        @(posedge clk);
        #1;

        // Back-to-back stream: one result per cycle.
        pop_cyc.delete();
        issue(ALU_ADD, 32'd1, 32'd10);
        issue(ALU_ADD, 32'd2, 32'd20);
        issue(ALU_ADD, 32'd3, 32'd30);
        issue(ALU_ADD, 32'd4, 32'd40);
        repeat (2) @(negedge clk);
        chk("stream_count", 32'(pop_cyc.size()), 32'd4);
        if (pop_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk("stream_gap", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        run("illegal", 4'b1111, 32'd2, 32'd3, 1, 0);
        chk("illegal_val", ALUResult, 32'd5);

        // Reset during a long shift drops the pending result.
        issue(ALU_SLL, 32'd3, 32'd20);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, barrel ? 32'd0 : 32'd1);
        chk("mid_in_ready", {31'd0, in_ready}, barrel ? 32'd1 : 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_zero", {31'd0, Zero}, 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("no_stale_result", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        run("post_abort", ALU_ADD, 32'd100, 32'd23, 1, 0);
        chk("post_abort_val", ALUResult, 32'd123);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU sitting directly downstream of the ALU decoder. Consumes the 4-bit ALUControl code plus two 32-bit operands and produces a registered ALUResult and Zero flag.
- Uses a valid/ready handshake on input and output so a stalled consumer back-pressures the pipeline.
- Add/sub/compare/logic/pass ops complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter, unless the barrel option is compiled in.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- ALU_CTRL_WIDTH, 4, width of the ALUControl code.
- SHAMT_WIDTH, 5, shift-amount bits taken from SrcB[SHAMT_WIDTH-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- ALUControl  input  ALU_CTRL_WIDTH  operation code.
- SrcA  input  DATA_WIDTH  operand A.
- SrcB  input  DATA_WIDTH  operand B / shift amount.
- out_valid  output  1  ALUResult/Zero hold a valid result.
- out_ready  input  1  consumer accepts the result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  high when ALUResult == 0; registered with ALUResult.
- busy  output  1  high while in SHIFT state.

Behaviour:
- Reset: one clock domain; reset is asynchronous, active-low on rst_n. While rst_n is low: state = IDLE, out_valid = 0, ALUResult = 0, Zero = 1, busy = 0, internal shift count = 0.
- Codes:
  - 0000 add, 0001 sub, 0010 sll, 0011 slt (signed), 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.
  - 1011 pass SrcB, used for U/J-type.
  - Any other code executes as add.
  - Arithmetic is modulo 2^DATA_WIDTH; overflow is ignored.
  - slt/sltu return 1 or 0, zero-extended.
- Handshake:
  - An operation is accepted on a cycle where in_valid && in_ready.
  - A result is consumed on a cycle where out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Operands need only be stable in the accept cycle; the unit captures them internally.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept of a non-shift op: result registered at that clock edge; next state DONE, out_valid = 1. Latency is 1 cycle.
  - IDLE, accept of a shift op with shamt != 0: capture SrcA, shamt and op; next state SHIFT, busy = 1.
  - IDLE, accept of a shift op with shamt == 0: ALUResult = SrcA; go straight to DONE (latency 1).
  - SHIFT: shift the working register 1 bit per cycle and decrement the count.
    - sll shifts in 0 at the LSB; srl shifts in 0 at the MSB; sra replicates the captured sign bit.
    - When the count reaches 1, that final shift writes ALUResult; next state DONE.
    - Total latency is 1 + shamt cycles; maximum 32 for shamt = 31.
  - SHIFT ignores in_valid; in_ready = 0.
  - DONE: out_valid = 1, and ALUResult/Zero hold steady until consumed.
    - out_ready = 0: stay in DONE.
    - out_ready = 1 with no new accept: go to IDLE; out_valid = 0 next cycle.
    - out_ready = 1 with a simultaneous accept: treat as an accept from IDLE. This gives back-to-back single-cycle ops at one result per cycle.
- ALUResult and Zero change only when a new result is written; they are never cleared on consume.
- Reset asserted mid-SHIFT or in DONE aborts the operation and the pending result is lost.

Optional Feature:
- ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and complete in 1 cycle like every other op. The SHIFT state and busy logic are not built; busy is tied to 0.
- Undefined: the iterative serial shifter described above is used.
- ALUResult values are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg holds:
  - the ALUControl code constants (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB);
  - the state enum typedef alu_state_t {IDLE, SHIFT, DONE};
  - a function is_shift(code).
- The decoder also imports this package.
- One sub-module, alu_serial_shifter: holds the working register and count, with load/done outputs. It is instantiated only when ALU_BARREL_SHIFT_EN is undefined.

Test Plan:
- Reset: hold rst_n low, drive in_valid=1 -> out_valid=0, ALUResult=0, Zero=1, busy=0; after release, in_ready=1.
- Single-cycle ops with out_ready=1, each result seen one cycle after accept:
  - sub 5-5 -> ALUResult=0, Zero=1.
  - slt 0xFFFFFFFF vs 1 -> 1.
  - sltu 0xFFFFFFFF vs 1 -> 0.
  - passB 0x12345000 -> 0x12345000.
- Shifts, serial build:
  - sra 0x80000000 by 4 -> 0xF8000000 after 5 cycles, busy high for 4 cycles.
  - sll 1 by 31 -> 0x80000000 after 32 cycles.
  - srl by 0 -> SrcA after 1 cycle.
- Back-pressure: hold out_ready=0 for 3 cycles after an add 7+8 -> out_valid stays 1, ALUResult stays 15, in_ready=0. Raise out_ready together with a new in_valid xor -> xor result on the next cycle with no bubble.
- Stream of 4 adds with out_ready=1 -> 4 results on 4 consecutive cycles. An illegal code 1111 with operands 2,3 -> 5.
- Reset mid-SHIFT (sll by 20, rst_n low at cycle 6) -> immediate IDLE, out_valid=0; no stale result after release. Repeat with ALU_BARREL_SHIFT_EN defined -> every shift has 1-cycle latency and the same values.
